laser_shot_sequencer: RTL and testbench

LASER_SHOT_SEQUENCER -- requirements
Module: laser_shot_sequencer

---
 rtl/laser_shot_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_laser_shot_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : laser_shot_sequencer
// Description : Fires periodic one-cycle laser strobes, opens a measurement
//               gate after each fire, and forwards the TDC result stream with
//               the valid flag masked to in-window hits on one channel.
//               Counts shots, out-of-window drops and flags empty windows.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_shot_sequencer #(
  parameter logic [2:0]  P_CH_ID      = 3'd0,
  parameter logic [15:0] P_MIN_PERIOD = 16'd100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  input  logic [15:0] i_window,
  input  logic        i_tdc_result_valid_flag,
  input  logic [2:0]  i_tdc_result_channel_id,
  input  logic        i_tdc_result_edge_id,
  input  logic [18:0] i_tdc_result,
  output logic        o_laser_str,
  output logic        o_tdc_result_valid_flag,
  output logic [2:0]  o_tdc_result_channel_id,
  output logic        o_tdc_result_edge_id,
  output logic [18:0] o_tdc_result,
  output logic        o_gate,
  output logic [15:0] o_shot_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_no_hit,
  output logic        o_busy
);

  localparam logic [15:0] C_MIN_WINDOW = 16'd1;
  localparam logic [7:0]  C_HIT_MAX    = 8'hFF;
  localparam logic [15:0] C_DROP_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_WINDOW  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_cnt;
  logic [15:0] r_eff_period;
  logic [15:0] r_eff_window;
  logic [7:0]  r_hit_cnt;
  logic [15:0] r_shot_cnt;
  logic [15:0] r_drop_cnt;
  logic        r_no_hit;

  logic        r_tdc_valid;
  logic [2:0]  r_tdc_channel_id;
  logic        r_tdc_edge_id;
  logic [18:0] r_tdc_result;

  logic [15:0] w_eff_period;
  logic [15:0] w_window_max;
  logic [15:0] w_eff_window;
  logic        w_in_window;
  logic        w_ch_match;
  logic        w_hit;
  logic        w_drop;
  logic        w_window_end;
  logic        w_period_end;

  // Shadow values for the next shot; the window is capped at period-2 so
  // every shot keeps at least one HOLDOFF cycle (P_MIN_PERIOD must be >= 3).
  assign w_eff_period = (i_period < P_MIN_PERIOD) ? P_MIN_PERIOD : i_period;
  assign w_window_max = w_eff_period - 16'd2;
  assign w_eff_window = (i_window < C_MIN_WINDOW) ? C_MIN_WINDOW :
                        (i_window > w_window_max) ? w_window_max : i_window;

  // r_cnt holds the number of cycles since the fire (0 during FIRE), so the
  // gate spans cnt = 1..eff_window and the next fire lands at cnt = eff_period.
  assign w_window_end = (r_cnt == r_eff_window);
  assign w_period_end = (r_cnt == (r_eff_period - 16'd1));

  assign w_in_window  = (r_state == ST_WINDOW);
  assign w_ch_match   = (i_tdc_result_channel_id == P_CH_ID);
  assign w_hit        = i_tdc_result_valid_flag & w_ch_match & w_in_window;
  assign w_drop       = i_tdc_result_valid_flag & w_ch_match & ~w_in_window;

  // State-decoded strobes; async reset of r_state drops them immediately.
  assign o_laser_str  = (r_state == ST_FIRE);
  assign o_gate       = w_in_window;
  assign o_busy       = (r_state != ST_IDLE);

  assign o_shot_cnt   = r_shot_cnt;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_no_hit     = r_no_hit;

  assign o_tdc_result_valid_flag = r_tdc_valid;
  assign o_tdc_result_channel_id = r_tdc_channel_id;
  assign o_tdc_result_edge_id    = r_tdc_edge_id;
  assign o_tdc_result            = r_tdc_result;

  // Next-state decode; HOLDOFF always runs to the end of the period so a
  // shot in flight is never cut short by i_enable dropping.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_FIRE;
        end
      end
      ST_FIRE: begin
        w_state_nxt = ST_WINDOW;
      end
      ST_WINDOW: begin
        if (w_window_end) begin
          w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (w_period_end) begin
          w_state_nxt = i_enable ? ST_FIRE : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cycle counter: zero on entry to FIRE or IDLE, counting up otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if ((w_state_nxt == ST_FIRE) || (w_state_nxt == ST_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Shadow period/window captured once per shot, during FIRE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_eff_period <= P_MIN_PERIOD;
      r_eff_window <= C_MIN_WINDOW;
    end else if (r_state == ST_FIRE) begin
      r_eff_period <= w_eff_period;
      r_eff_window <= w_eff_window;
    end
  end

  // Per-shot hit counter (both edges), saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_cnt <= '0;
    end else if (r_state == ST_FIRE) begin
      r_hit_cnt <= '0;
    end else if (w_hit && (r_hit_cnt != C_HIT_MAX)) begin
      r_hit_cnt <= r_hit_cnt + 8'd1;
    end
  end

  // Empty-window flag; a hit on the closing cycle still counts as in-window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_no_hit <= 1'b0;
    end else begin
      r_no_hit <= w_in_window & w_window_end & (r_hit_cnt == 8'd0) & ~w_hit;
    end
  end

  // Shot counter, wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shot_cnt <= '0;
    end else if (r_state == ST_FIRE) begin
      r_shot_cnt <= r_shot_cnt + 16'd1;
    end
  end

  // Out-of-window drop counter for the selected channel, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != C_DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // TDC stream register: payload passes through, valid masked to gated hits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tdc_valid      <= 1'b0;
      r_tdc_channel_id <= '0;
      r_tdc_edge_id    <= 1'b0;
      r_tdc_result     <= '0;
    end else begin
      r_tdc_valid      <= w_hit;
      r_tdc_channel_id <= i_tdc_result_channel_id;
      r_tdc_edge_id    <= i_tdc_result_edge_id;
      r_tdc_result     <= i_tdc_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_shot_sequencer
// Description : Self-checking bench for laser_shot_sequencer: shot timing,
//               period/window clamping, TDC gating, drop/no-hit counting,
//               enable drop-out and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_shot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic [15:0] period;
  logic [15:0] window;
  logic        tdc_v;
  logic [2:0]  tdc_ch;
  logic        tdc_e;
  logic [18:0] tdc_res;
  logic        laser;
  logic        o_v;
  logic [2:0]  o_ch;
  logic        o_e;
  logic [18:0] o_res;
  logic        gate;
  logic [15:0] shot_cnt;
  logic [15:0] drop_cnt;
  logic        no_hit;
  logic        busy;

  laser_shot_sequencer #(
    .P_CH_ID      (3'd0),
    .P_MIN_PERIOD (16'd100)
  ) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_enable                (en),
    .i_period                (period),
    .i_window                (window),
    .i_tdc_result_valid_flag (tdc_v),
    .i_tdc_result_channel_id (tdc_ch),
    .i_tdc_result_edge_id    (tdc_e),
    .i_tdc_result            (tdc_res),
    .o_laser_str             (laser),
    .o_tdc_result_valid_flag (o_v),
    .o_tdc_result_channel_id (o_ch),
    .o_tdc_result_edge_id    (o_e),
    .o_tdc_result            (o_res),
    .o_gate                  (gate),
    .o_shot_cnt              (shot_cnt),
    .o_drop_cnt              (drop_cnt),
    .o_no_hit                (no_hit),
    .o_busy                  (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus vectors, offsets in cycles after the fire (t=0 is the FIRE cycle).
  typedef struct {
    int          t;
    logic        v;
    logic [2:0]  ch;
    logic        e;
    logic [18:0] res;
    logic        exp_v;
    logic        exp_drop;
  } vec_t;

  localparam int N_VEC = 9;
  vec_t vecs[N_VEC];

  // Scoreboard of forwarded TDC words, keyed by the cycle they must appear.
  typedef struct {
    int unsigned due;
    logic [23:0] word;
  } sb_t;
  sb_t sb_q[$];
  sb_t m_exp;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      m_exp = sb_q.pop_front();
      check("tdc_fwd", 32'({o_v, o_ch, o_e, o_res}), 32'(m_exp.word));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    tdc_v   = 1'b0;
    tdc_ch  = 3'd0;
    tdc_e   = 1'b0;
    tdc_res = 19'd0;
  endtask

  task automatic apply_vec(input int i);
    sb_t item;
    tdc_v   = vecs[i].v;
    tdc_ch  = vecs[i].ch;
    tdc_e   = vecs[i].e;
    tdc_res = vecs[i].res;
    item.due  = cyc + 1;
    item.word = {vecs[i].exp_v, vecs[i].ch, vecs[i].e, vecs[i].res};
    sb_q.push_back(item);
  endtask

  // Runs n_shots shots starting in a FIRE cycle and checks their timing;
  // at t=30 of each shot the period/window inputs are changed.
  task automatic run_shots(input int n_shots, input int per, input int win,
                           input bit use_tbl, input logic [15:0] new_per,
                           input logic [15:0] new_win);
    for (int s = 0; s < n_shots; s++) begin
      int gate_len;
      int gate_first;
      int n_laser;
      int n_nohit;
      int nohit_t;
      gate_len = 0; gate_first = -1; n_laser = 0; n_nohit = 0; nohit_t = -1;
      for (int t = 0; t < per; t++) begin
        drive_idle();
        if (use_tbl && s == 0) begin
          for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].t == t) apply_vec(i);
          end
        end
        if (t == 30) begin
          period = new_per;
          window = new_win;
        end
        step();
        if (t + 1 < per) begin
          if (laser) n_laser++;
          if (gate) begin
            gate_len++;
            if (gate_first < 0) gate_first = t + 1;
          end
          if (no_hit) begin
            n_nohit++;
            nohit_t = t + 1;
          end
        end
      end
      check("fire_spacing", 32'(laser), 32'd1);
      check("stray_fire", n_laser, 0);
      check("gate_len", gate_len, win);
      check("gate_start", gate_first, 1);
      if (use_tbl && s == 0) begin
        check("no_hit_with_hits", n_nohit, 0);
      end else begin
        check("no_hit_count", n_nohit, 1);
        check("no_hit_time", nohit_t, win + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_drops;
    int bad;
    int g;
    int nl;
    int k;

    // {t, valid, ch, edge, result, expected forwarded valid, counts as drop}
    vecs[0] = '{0,   1'b1, 3'd0, 1'b1, 19'h00111, 1'b0, 1'b1};  // during FIRE
    vecs[1] = '{1,   1'b1, 3'd0, 1'b0, 19'h00222, 1'b1, 1'b0};  // first gate cycle
    vecs[2] = '{5,   1'b1, 3'd0, 1'b1, 19'h12345, 1'b1, 1'b0};  // rising edge in window
    vecs[3] = '{7,   1'b1, 3'd3, 1'b1, 19'h7ABCD, 1'b0, 1'b0};  // other channel
    vecs[4] = '{50,  1'b1, 3'd0, 1'b0, 19'h40001, 1'b1, 1'b0};  // closing cycle
    vecs[5] = '{51,  1'b1, 3'd0, 1'b1, 19'h00055, 1'b0, 1'b1};  // first holdoff cycle
    vecs[6] = '{60,  1'b1, 3'd0, 1'b1, 19'h6F00F, 1'b0, 1'b1};  // 10 after close
    vecs[7] = '{70,  1'b0, 3'd0, 1'b0, 19'h00777, 1'b0, 1'b0};  // not valid
    vecs[8] = '{120, 1'b1, 3'd5, 1'b0, 19'h1FFFF, 1'b0, 1'b0};  // other channel
    exp_drops = 0;
    for (int i = 0; i < N_VEC; i++) exp_drops += int'(vecs[i].exp_drop);

    en = 1'b0; period = 16'd200; window = 16'd50;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_laser", 32'(laser), 32'd0);
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_hit", 32'(no_hit), 32'd0);
    check("rst_shot_cnt", 32'(shot_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_tdc", 32'({o_v, o_ch, o_e, o_res}), 32'd0);

    // No fire while enable is low after release.
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      step();
      if (laser || busy) bad++;
    end
    check("idle_without_enable", bad, 0);

    en = 1'b1;
    step();
    check("first_fire", 32'(laser), 32'd1);
    check("shot_cnt_at_first_fire", 32'(shot_cnt), 32'd0);

    run_shots(5, 200, 50, 1'b1, 16'd200, 16'd50);
    check("shot_cnt_after_5", 32'(shot_cnt), 32'd5);
    check("drop_cnt", 32'(drop_cnt), exp_drops);

    // Asynchronous reset while the strobe is high, with TDC inputs active.
    tdc_v = 1'b1; tdc_ch = 3'd2; tdc_e = 1'b1; tdc_res = 19'h5A5A5;
    #1 rst_n = 1'b0;
    #1;
    check("reset_laser_drop", 32'(laser), 32'd0);
    check("reset_shot_cnt", 32'(shot_cnt), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (2) step();
    check("reset_tdc_held", 32'({o_v, o_ch, o_e, o_res}), 32'd0);
    check("reset_laser_held", 32'(laser), 32'd0);

    drive_idle();
    en = 1'b0; period = 16'd10; window = 16'd500;
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      step();
      if (laser || busy) bad++;
    end
    check("idle_after_reset", bad, 0);
    en = 1'b1;
    step();
    check("first_fire_after_reset", 32'(laser), 32'd1);

    // Clamped shot (period 10 -> 100, window 500 -> 98); mid-shot changes
    // to 200/50 must not affect this shot.
    run_shots(1, 100, 98, 1'b0, 16'd200, 16'd50);

    // 200/50 shot with enable dropped at t=20: shot completes, then idle.
    g = 0; nl = 0; k = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (gate) g++;
      if (laser) nl++;
    end
    en = 1'b0;
    while (k < 400 && busy) begin
      step();
      k++;
      if (gate) g++;
      if (laser) nl++;
    end
    check("busy_fall_delay", k, 180);
    check("no_fire_after_disable", nl, 0);
    check("gate_len_new_window", g, 50);
    nl = 0;
    repeat (10) begin
      step();
      if (laser || busy) nl++;
    end
    check("stays_idle", nl, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
